// File: rtl/decode_buffer_pkg.sv
// rtl/decode_buffer_pkg.sv - fetch entry type, zero constant and next-pc helper
// Exports:
//   fetch_entry_type  one queued fetch result (pc, instr, exception, ecause, etval)
//   init_fetch_entry  all-zero entry, driven to decode whenever the queue is empty
//   next_pc()         pc + 4 for 32-bit encodings, pc + 2 for compressed ones
package decode_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exception;
    logic [3:0]  ecause;
    logic [31:0] etval;
  } fetch_entry_type;

  localparam fetch_entry_type init_fetch_entry = '0;

  // Only the two length bits of the instruction matter; the add wraps mod 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [1:0] ilen);
    return (ilen == 2'b11) ? pc + 32'd4 : pc + 32'd2;
  endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// rtl/decode_buffer_if.sv - fetch-to-decode queue signal bundle
// Signals:
//   in_*        fetch side entry with in_valid/in_ready handshake
//   clear,stall pipeline flush and decode/execute stall
//   out_*       head entry and its next pc, gated to zero when out_valid=0
//   count,afull occupancy and throttling hint
// Modports: slave = the queue, master = the fetch/decode environment.
interface decode_buffer_if #(
  parameter int DEPTH = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [31:0]              in_instr;
  logic                     in_exception;
  logic [3:0]               in_ecause;
  logic [31:0]              in_etval;
  logic                     clear;
  logic                     stall;
  logic                     out_valid;
  logic [31:0]              out_pc;
  logic [31:0]              out_npc;
  logic [31:0]              out_instr;
  logic                     out_exception;
  logic [3:0]               out_ecause;
  logic [31:0]              out_etval;
  logic [$clog2(DEPTH):0]   count;
  logic                     afull;

  modport slave (
    input  in_valid, in_pc, in_instr, in_exception, in_ecause, in_etval, clear, stall,
    output in_ready, out_valid, out_pc, out_npc, out_instr, out_exception, out_ecause,
           out_etval, count, afull
  );

  modport master (
    output in_valid, in_pc, in_instr, in_exception, in_ecause, in_etval, clear, stall,
    input  in_ready, out_valid, out_pc, out_npc, out_instr, out_exception, out_ecause,
           out_etval, count, afull
  );

endinterface

// File: rtl/decode_buffer.sv
// rtl/decode_buffer.sv - instruction queue between fetch and decode_stage
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset (pointers only; storage is not reset)
//   bus  decode_buffer_if.slave: fetch entry in, head entry + npc out,
//        clear/stall controls, count/afull status
// Parameters: DEPTH entries (power of two, >= 2), AFULL threshold for afull.
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  decode_buffer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_LVL = AFULL[AW:0];

  // MSB of each pointer is the wrap bit; it tells full from empty when the
  // index bits match.
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     occ;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  fetch_entry_type buffer [DEPTH];
  fetch_entry_type wr_entry;
  fetch_entry_type head;
  fetch_entry_type out_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign occ   = wr_ptr - rd_ptr;

  // clear suppresses both transfers so nothing is half-committed on a flush.
  assign push = bus.in_valid & ~full & ~bus.clear;
  assign pop  = ~empty & ~bus.stall & ~bus.clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign wr_entry = '{pc:        bus.in_pc,
                      instr:     bus.in_instr,
                      exception: bus.in_exception,
                      ecause:    bus.in_ecause,
                      etval:     bus.in_etval};

  // Storage carries no reset; the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push) buffer[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign head = buffer[rd_ptr[AW-1:0]];

  // Stale or flushed slots must never leak to decode, so gate to zero.
  always_comb begin
    out_entry = init_fetch_entry;
    if (!empty) out_entry = head;
  end

  assign bus.in_ready      = ~full;
  assign bus.out_valid     = ~empty;
  assign bus.out_pc        = out_entry.pc;
  assign bus.out_instr     = out_entry.instr;
  assign bus.out_exception = out_entry.exception;
  assign bus.out_ecause    = out_entry.ecause;
  assign bus.out_etval     = out_entry.etval;
  assign bus.out_npc       = empty ? 32'd0 : next_pc(head.pc, head.instr[1:0]);
  assign bus.count         = occ;
  assign bus.afull         = (occ >= AFULL_LVL);

endmodule

// File: doc/decode_buffer.md
# decode_buffer

- Parametrised instruction queue between the fetch stage and `decode_stage`.
- Holds up to DEPTH fetched entries: pc, instr, exception, ecause, etval.
- Fetch keeps running while decode or execute stall; the whole queue is flushed in one cycle on a pipeline clear.
- Presents the head entry plus its next-pc (16/32-bit aware) to decode.

## Interface

Parameters:
- DEPTH, 4: number of entries; power of two, ≥ 2.
- AFULL, DEPTH-1: occupancy at or above which `afull` asserts; 1 ≤ AFULL ≤ DEPTH.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue accepts an entry; equals `count != DEPTH`.
- in_pc  in  32  pc of the fetched instruction.
- in_instr  in  32  raw instruction (compressed in [15:0] when [1:0] != 2'b11).
- in_exception  in  1  fetch fault.
- in_ecause  in  4  fault cause.
- in_etval  in  32  fault value.
- clear  in  1  flush: decode jump | exception | mret | execute clear.
- stall  in  1  decode stall | execute stall.
- out_valid  out  1  head entry valid.
- out_pc  out  32  head pc.
- out_npc  out  32  head pc + 4 if instr[1:0]==2'b11, else + 2.
- out_instr  out  32  head instruction.
- out_exception  out  1  head fault.
- out_ecause  out  4  head cause.
- out_etval  out  32  head fault value.
- count  out  $clog2(DEPTH)+1  current occupancy.
- afull  out  1  `count >= AFULL`; fetch throttling hint.

## Operation

- Circular storage of DEPTH entries.
- Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Status: empty when pointers are equal; full when the index bits are equal and the wrap bits differ.
- push = in_valid & in_ready & !clear.
- pop = out_valid & !stall & !clear.
- push and pop may both occur in one cycle: count is unchanged and both pointers advance.
- Full:
  - in_ready=0, so no push, even when a pop happens that cycle.
  - There is no pass-through of an incoming entry while full.
- Empty: out_valid=0 and no pop. There is no same-cycle bypass from input to output.
- clear:
  - Both pointers and count go to 0 on the next edge.
  - Any push or pop in the same cycle is discarded; clear wins over every other event.
- Output gating:
  - out_* data come from the head entry when out_valid=1.
  - When out_valid=0 they are forced to 0, so flushed or stale data never reach decode.
- Faulting entries (in_exception=1) are queued and popped like any other entry. The queue never interprets them.
- out_npc: 32-bit add, wraps modulo 2^32 (pc 0xFFFF_FFFE + 2 = 0x0000_0000).
- Storage contents are not reset; only the pointers are.

## Timing

- Reset (rst=0, asynchronous), all outputs take these values without a clock edge:
  - out_valid=0, count=0, afull=0.
  - in_ready=1, all out_* data=0.
- Push-to-output latency:
  - An entry pushed at edge N appears on out_* after edge N, i.e. out_valid=1 in cycle N+1.
  - Minimum 1 cycle.
- Pop:
  - The head advances at the edge where pop=1.
  - The next entry, if any, is visible in the following cycle.
- Throughput: one push and one pop per cycle sustained whenever stall=0.
- in_ready, out_valid, count and afull are decoded purely from registered pointers; there is no combinational path from any input to them.
- out_npc is combinational from the head entry.
- Reset asserted mid-operation: the queue is empty immediately. Entries are lost and no partial pop occurs.
- Deassertion of rst is synchronised externally.

## Structure

- wires package gets `fetch_entry_type` with fields pc, instr, exception, ecause, etval.
- constants package gets `init_fetch_entry` (all zero).
- The storage array is declared `fetch_entry_type buffer[DEPTH]`.
- No sub-module: pointer logic, storage and output mux stay inline.
- Top level instantiates it between the fetch stage and `decode_stage`:
  - `decode_stage` takes its `d.f` fields from out_*.
  - Its clear and stall terms drive clear and stall here.

## Test plan

- Reset, then push pc=0x100 instr=0x00000013:
  - in_ready=1 throughout.
  - Next cycle out_valid=1, out_pc=0x100, out_npc=0x104, count=1.
- Push 4 entries with stall=1 (DEPTH=4):
  - count=4, in_ready=0, afull=1.
  - A 5th push attempt is dropped.
  - Release stall: pops return the 4 pcs in order.
- Sustained push+pop with stall=0, compressed instr 0x4501 at pc=0x202:
  - out_npc=0x204.
  - count stays constant.
- Three entries queued, then clear=1 together with in_valid=1:
  - Next cycle count=0, out_valid=0, out_pc=0.
  - The incoming entry is not stored.
- Pointer wrap, DEPTH=4: push/pop 10 entries with random stalls.
  - Order preserved, count never exceeds 4.
  - The full and empty flags are correct across the wrap.
- Entry with in_exception=1, ecause=1, etval=0x8000_0003 queued behind two normal entries:
  - It is delivered third with all fault fields intact.
  - rst pulsed low mid-stream clears out_valid asynchronously.
